// File: rtl/banco_registros.sv
// banco_registros: 2R/1W register file with r0 hard-wired to zero and a post-reset clearing sweep
module banco_registros #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] ra1_i,
  input  logic [ADDR_W-1:0] ra2_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i,
  output logic              busy_o
);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic busy_n;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= CLEAR;
      cnt    <= ADDR_W'(1);
      busy_o <= 1'b1;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      busy_o <= busy_n;
    end
  end
  always_comb begin
    state_n = (state == CLEAR && cnt == '1) ? IDLE : state;
    cnt_n   = (state == CLEAR) ? cnt + 1'b1 : cnt;
    busy_n  = state_n == CLEAR;
  end
  // Storage has no reset; the sweep zeroes it one entry per edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state == CLEAR) mem[cnt] <= '0;
      else if (we_i && wa_i != '0) mem[wa_i] <= wd_i;
    end
  end
  assign rd1_o = (busy_o || ra1_i == '0) ? '0 : (BYPASS && we_i && ra1_i == wa_i) ? wd_i : mem[ra1_i];
  assign rd2_o = (busy_o || ra2_i == '0) ? '0 : (BYPASS && we_i && ra2_i == wa_i) ? wd_i : mem[ra2_i];
endmodule

// File: doc/banco_registros.md
# banco_registros

Register file feeding the single-cycle datapath's ALU slices: two combinational read ports supply the A/B operands, one clocked write port takes back the ALU result. Register 0 is hard-wired to zero. The storage array has no per-bit reset; reset starts a clearing sweep controlled by an internal state machine. The `busy_o` flag holds off the control unit until the sweep finishes.

## Interface
- `DATA_W`, default 32: width of each register and of the data ports.
- `ADDR_W`, default 5: address width; the array holds `2**ADDR_W` entries.
- `BYPASS`, default 1: 1 enables write-to-read forwarding in the same cycle; 0 disables it.

Ports:
- `clk_i` in, 1: single clock; all state updates on the rising edge.
- `rst_i` in, 1: reset, synchronous and active-high.
- `ra1_i` in, `ADDR_W`: read address, port 1 (operand A).
- `ra2_i` in, `ADDR_W`: read address, port 2 (operand B).
- `rd1_o` out, `DATA_W`: read data, port 1.
- `rd2_o` out, `DATA_W`: read data, port 2.
- `we_i` in, 1: write enable.
- `wa_i` in, `ADDR_W`: write address.
- `wd_i` in, `DATA_W`: write data (ALU result).
- `busy_o` out, 1: clearing sweep in progress; registered.

## Operation
- **States:**
  - `CLEAR`: sweeping.
  - `IDLE`: normal operation.
  - Internal sweep counter `cnt`, `ADDR_W` bits.
- **Reset:** any edge with `rst_i`=1 sets state to `CLEAR`, `cnt` to 1 and `busy_o` to 1.
  - `rst_i` has priority over everything else.
  - Holding `rst_i` high keeps the block parked at `cnt`=1.
- **`CLEAR` with `rst_i`=0:** each edge writes 0 to `reg[cnt]` and increments `cnt`.
  - The edge that clears `reg[2**ADDR_W-1]` moves to `IDLE` and sets `busy_o` to 0.
  - `cnt` wraps to 0; the value is unused.
- **Reset mid-sweep:** restarts at `cnt`=1. Registers already cleared stay 0.
- **Write:**
  - At the edge, in `IDLE`, with `we_i`=1 and `wa_i`≠0: `reg[wa_i]` takes `wd_i`.
  - Writes to address 0 are discarded.
  - Writes while `busy_o`=1 or `rst_i`=1 are discarded.
- **Read, each port independently, combinational:**
  - While `busy_o`=1: 0, for every address.
  - Address 0: 0.
  - `BYPASS`=1 and the read address equals `wa_i` with `we_i`=1 (address ≠ 0, `IDLE`): `wd_i`.
  - Otherwise: `reg[ra]`.
- **Shared addresses:** both ports may address the same register. Each returns the same value.
- **Power-up:** contents are undefined until the first reset completes a sweep. Reads still return 0 during that time only if `busy_o`=1.

## Timing
- **Read latency:** 0 cycles, combinational from the address and bypass inputs.
- **Write latency:** the value is visible on a read port the cycle after the write edge, or in the same cycle via bypass when `BYPASS`=1.
- **Sweep length:** `2**ADDR_W - 1` edges after `rst_i` falls (31 with defaults).
  - `busy_o` is 1 through the edge that clears the last register.
  - `busy_o` is 0 after that edge.
- **Reset values:** `busy_o`=1, state `CLEAR`, `cnt`=1.
  - `rd1_o`/`rd2_o` read 0 while busy.
- **Single write:** there is one write port, so no write-write conflicts are possible.
- **Read during write:** with `BYPASS`=0, a read of the written address returns the old contents until the edge.

## Test plan
- **Reset sweep:**
  - Stimulus: preload `reg[5]`=`0xDEADBEEF`; assert `rst_i` for 2 cycles, then release.
  - Required: `busy_o` stays 1 for 31 edges after release, then 0; `rd1_o` reads 0 at address 5.
- **Basic write/read:**
  - Stimulus: `we_i`=1, `wa_i`=7, `wd_i`=`0x12345678`.
  - Required: the next cycle, `ra1_i`=7 gives `rd1_o`=`0x12345678`; `ra2_i`=7 gives the same on `rd2_o`.
- **Register 0:**
  - Stimulus: write `0xFFFFFFFF` to address 0.
  - Required: `rd1_o` and `rd2_o` read 0 at address 0, both during and after the write cycle.
- **Bypass:**
  - Stimulus: with `BYPASS`=1, write `0xA5A5A5A5` to address 3 while `ra1_i`=3.
  - Required: `rd1_o`=`0xA5A5A5A5` in the same cycle.
  - With `BYPASS`=0 and the old value 0: `rd1_o`=0 that cycle, then `0xA5A5A5A5`.
- **Write while busy:**
  - Stimulus: during a sweep, at `cnt`=10, write `0x55` to address 20.
  - Required: after the sweep, address 20 reads 0.
- **Reset mid-sweep:**
  - Stimulus: pulse `rst_i` for 1 cycle at sweep edge 15.
  - Required: `busy_o` stays 1 for a full 31 edges after the pulse; all registers read 0 afterwards.
